// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: req/ack SRAM handshake with pipeline stall,
// byte-lane steering for stores, aligned/extended load return, misalign detection and timeout.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        start_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [31:0] instr_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        misalign_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        load_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic [31:0] rdata_q;
    logic        rdata_valid_q;
    logic        misalign_q;
    logic        err_q;

    logic [2:0]  f3_s;
    logic        memop_s;
    logic        misalign_s;
    logic        unused_instr_s;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            2'b00:   lanes = {4{data[7:0]}};
            2'b01:   lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'd0, sh[7:0]};
            3'b101:  res = {16'd0, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign f3_s       = instr_i[14:12];
    assign memop_s    = MemRead_i | MemWrite_i;
    assign misalign_s = ((f3_s[1:0] == 2'b01) && ALUResult_i[0]) ||
                        (f3_s[1] && (ALUResult_i[1:0] != 2'b00));
    assign cnt_d      = cnt_q + 8'd1;
    assign unused_instr_s = ^{instr_i[31:15], instr_i[11:0]};

    // The IDLE term must raise stall in the same cycle the request is seen; reset forces it low.
    assign stall_o = (state_q == ST_REQ) ||
                     ((state_q == ST_IDLE) && start_i && memop_s && !misalign_s);

    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misalign_o    = misalign_q;
    assign err_o         = err_q;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_be_o      = mem_be_q;

    // Access FSM with all registered outputs.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 8'd0;
            f3_q          <= 3'd0;
            off_q         <= 2'd0;
            load_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_wdata_q   <= 32'd0;
            mem_be_q      <= 4'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (memop_s && !misalign_s) begin
                        state_q     <= ST_REQ;
                        cnt_q       <= 8'd0;
                        f3_q        <= f3_s;
                        off_q       <= ALUResult_i[1:0];
                        load_q      <= !MemWrite_i;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= MemWrite_i;
                        mem_addr_q  <= {ALUResult_i[31:2], 2'b00};
                        mem_wdata_q <= store_lanes(f3_s[1:0], RDData_i);
                        mem_be_q    <= byte_enable(f3_s[1:0], ALUResult_i[1:0]);
                    end else begin
                        misalign_q  <= memop_s && misalign_s;
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a timeout reached in the same cycle.
                    if (mem_ack_i) begin
                        state_q       <= ST_DONE;
                        mem_req_q     <= 1'b0;
                        rdata_valid_q <= load_q;
                        if (load_q) begin
                            rdata_q <= load_extract(f3_q, off_q, mem_rdata_i);
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else if ((TIMEOUT_C != 8'd0) && (cnt_d == TIMEOUT_C)) begin
                        state_q       <= ST_DONE;
                        mem_req_q     <= 1'b0;
                        err_q         <= 1'b1;
                        rdata_q       <= 32'd0;
                        rdata_valid_q <= load_q;
                        cnt_q         <= cnt_d;
                    end else begin
                        cnt_q         <= cnt_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner sequences and
// randomized accesses checked against a byte-level reference model.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk_i;
    logic        start_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RDData_i;
    logic [31:0] instr_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misalign_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int   vectors;
    int   misses;
    logic err_exp;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clk_i        (clk_i),
        .start_i      (start_i),
        .MemRead_i    (MemRead_i),
        .MemWrite_i   (MemWrite_i),
        .ALUResult_i  (ALUResult_i),
        .RDData_i     (RDData_i),
        .instr_i      (instr_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rdata_valid_o(rdata_valid_o),
        .misalign_o   (misalign_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_ack_i    (mem_ack_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] rword;
        int          wait_n;
        logic [31:0] e_rdata;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: access width in bytes, byte-lane view of the bus.
    function automatic int size_of(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % size_of(f3)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int lane;
        be = 4'd0;
        for (int i = 0; i < size_of(f3); i++) begin
            lane = int'(a[1:0]) + i;
            if (lane < 4) be[lane] = 1'b1;
        end
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int sz;
        sz = size_of(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] word);
        logic [31:0] v;
        int sz;
        int base;
        sz   = size_of(f3);
        base = int'(a[1:0]);
        v    = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = word[8*(base + i) +: 8];
        if (sz < 4 && !f3[2] && v[8*sz-1]) begin
            for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic run_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] rword,
                          input int wait_n, input logic ack_en, input logic [31:0] e_rdata,
                          input logic [3:0] e_be, input logic [31:0] e_wdata, input logic e_mis);
        logic        memop;
        logic        is_load;
        logic        timed_out;
        logic [31:0] ins;
        int          reqc;
        memop     = rd | wr;
        is_load   = rd & ~wr;
        timed_out = 1'b0;
        reqc      = 0;
        ins       = $urandom;
        ins[14:12] = f3;
        @(negedge clk_i);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        ALUResult_i = addr;
        RDData_i    = wd;
        instr_i     = ins;
        mem_rdata_i = rword;
        mem_ack_i   = 1'($urandom_range(0, 1));
        #1;
        check("idle_stall", stall_o, memop & ~e_mis);
        check("idle_req", mem_req_o, 1'b0);
        check("idle_valid", rdata_valid_o, 1'b0);
        check("idle_mis", misalign_o, 1'b0);
        if (!memop || e_mis) begin
            @(negedge clk_i);
            MemRead_i  = 1'b0;
            MemWrite_i = 1'b0;
            mem_ack_i  = 1'b0;
            #1;
            check("misalign_pulse", misalign_o, e_mis);
            check("noop_req", mem_req_o, 1'b0);
            check("noop_stall", stall_o, 1'b0);
            return;
        end
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_i);
            mem_ack_i = ack_en && (k == wait_n);
            #1;
            check("req_high", mem_req_o, 1'b1);
            check("req_stall", stall_o, 1'b1);
            if (k == 0) begin
                check("req_addr", mem_addr_o, {addr[31:2], 2'b00});
                check("req_we", mem_we_o, wr);
                check("req_be", mem_be_o, e_be);
                check("req_wdata", mem_wdata_o, e_wdata);
            end
            reqc++;
            if (mem_ack_i) break;
            if (reqc == TO) begin
                timed_out = 1'b1;
                break;
            end
        end
        if (timed_out) err_exp = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'($urandom_range(0, 1));
        #1;
        check("done_stall", stall_o, 1'b0);
        check("done_req", mem_req_o, 1'b0);
        check("done_err", err_o, err_exp);
        if (timed_out) begin
            check("timeout_rdata", rdata_o, 32'd0);
        end else begin
            check("done_valid", rdata_valid_o, is_load);
            if (is_load) check("done_rdata", rdata_o, e_rdata);
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t        v;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rw;
        int          sz;

        vectors = 0;
        misses  = 0;
        err_exp = 1'b0;
        start_i     = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
        ALUResult_i = 32'd0;
        RDData_i    = 32'd0;
        instr_i     = 32'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_stall", stall_o, 1'b0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_valid", rdata_valid_o, 1'b0);
        check("rst_mis", misalign_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_we", mem_we_o, 1'b0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        check("rst_be", mem_be_o, 4'd0);
        @(negedge clk_i);
        start_i = 1'b1;

        //          rd    wr    addr         wd            f3      rword         w  e_rdata       e_be     e_wdata       mis
        tbl.push_back('{1'b1, 1'b0, 32'h100, 32'h0,        3'b010, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h103, 32'h0,        3'b000, 32'h80FF7F01, 0, 32'hFFFFFF80, 4'b1000, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h103, 32'h0,        3'b100, 32'h80FF7F01, 0, 32'h00000080, 4'b1000, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h202, 32'h1234ABCD, 3'b001, 32'h0,        3, 32'h0,        4'b1100, 32'hABCDABCD, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h101, 32'h0,        3'b010, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h002, 32'h0,        3'b001, 32'h80FF7F01, 1, 32'hFFFF80FF, 4'b1100, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h000, 32'h0,        3'b101, 32'h80FF7F01, 2, 32'h00007F01, 4'b0011, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h001, 32'h000000A5, 3'b000, 32'h0,        1, 32'h0,        4'b0010, 32'hA5A5A5A5, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 32'h010, 32'hCAFEF00D, 3'b010, 32'h0,        2, 32'h0,        4'b1111, 32'hCAFEF00D, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h003, 32'h0,        3'b001, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 1'b1, 32'h001, 32'h0,        3'b101, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h123, 32'h0,        3'b010, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h004, 32'h0,        3'b011, 32'h11223344, 0, 32'h11223344, 4'b1111, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'h002, 32'h0,        3'b110, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 1'b0, 32'h102, 32'h0,        3'b000, 32'h80FF7F01, 0, 32'hFFFFFFFF, 4'b0100, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'h008, 32'h55AA55AA, 3'b010, 32'h0,        0, 32'h0,        4'b1111, 32'h55AA55AA, 1'b0});

        foreach (tbl[i]) begin
            v = tbl[i];
            run_op(v.rd, v.wr, v.addr, v.wd, v.f3, v.rword, v.wait_n, 1'b1,
                   v.e_rdata, v.e_be, v.e_wdata, v.e_mis);
        end

        for (int n = 0; n < 200; n++) begin
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom;
            wd   = $urandom;
            rw   = $urandom;
            sz   = size_of(f3);
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'(int'(addr[1:0]) - (int'(addr[1:0]) % sz));
            run_op(rd, wr, addr, wd, f3, rw, int'($urandom_range(0, 3)), 1'b1,
                   m_load(f3, addr, rw), m_be(f3, addr), m_wdata(f3, wd),
                   (rd | wr) & m_mis(f3, addr));
        end

        // Hung memory: request held TO cycles, then sticky error with zero load data.
        run_op(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, 32'h12345678, 0, 1'b0,
               32'h0, 4'b1111, 32'h0, 1'b0);
        run_op(1'b1, 1'b0, 32'h44, 32'h0, 3'b010, 32'h0BADF00D, 1, 1'b1,
               32'h0BADF00D, 4'b1111, 32'h0, 1'b0);

        // Reset asserted in the second REQ cycle.
        @(negedge clk_i);
        MemRead_i   = 1'b1;
        MemWrite_i  = 1'b0;
        ALUResult_i = 32'h80;
        instr_i     = 32'h0000_2003;
        mem_ack_i   = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        check("rst_mid_req_before", mem_req_o, 1'b1);
        start_i = 1'b0;
        #1;
        check("rst_mid_req", mem_req_o, 1'b0);
        check("rst_mid_stall", stall_o, 1'b0);
        check("rst_mid_err", err_o, 1'b0);
        err_exp = 1'b0;
        @(negedge clk_i);
        start_i   = 1'b1;
        MemRead_i = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        check("post_rst_req", mem_req_o, 1'b0);
        check("post_rst_stall", stall_o, 1'b0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("late_ack_req", mem_req_o, 1'b0);
        check("late_ack_valid", rdata_valid_o, 1'b0);
        check("late_ack_err", err_o, 1'b0);
        run_op(1'b1, 1'b0, 32'h80, 32'h0, 3'b100, 32'h000000F0, 0, 1'b1,
               32'h000000F0, 4'b0001, 32'h0, 1'b0);

        @(negedge clk_i);
        MemRead_i  = 1'b0;
        MemWrite_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller for the MEM stage of the pipelined RV32 core. It consumes the registered memory request from the EX/MEM pipeline register: MemRead/MemWrite, ALU address, store data and instruction. It drives a req/ack handshake to an external data SRAM, stalls the pipeline until the access completes, and returns the aligned, sign- or zero-extended load result toward MEM/WB. It also detects misaligned accesses and times out a hung memory.

## Interface
- TIMEOUT, 255: REQ cycles without ack before abort; 0 disables the timeout.
- clk_i  in  1  core clock
- start_i  in  1  reset, asynchronous, active-low; block reset while low
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM; wins if both are high
- ALUResult_i  in  32  byte address
- RDData_i  in  32  store data (rs2)
- instr_i  in  32  instruction; funct3 = instr_i[14:12]
- stall_o  out  1  freeze PC/IF/ID/EX/EX-MEM registers
- rdata_o  out  32  extended load data
- rdata_valid_o  out  1  one-cycle pulse, rdata_o valid
- misalign_o  out  1  one-cycle pulse, cycle after misaligned access seen
- err_o  out  1  sticky timeout flag
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word address {ALUResult_i[31:2],2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_be_o  out  4  byte enables
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o=1
- mem_rdata_i  in  32  read word, valid with mem_ack_i

## Operation
- Width decode from funct3:
  - 000 LB/SB; 001 LH/SH; 010 LW/SW; 100 LBU; 101 LHU.
  - 011/110/111 are treated as word access.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No request issued and no stall.
  - misalign_o pulses in the next cycle.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 1100 : 0011
  - word: 1111
- Store data: byte replicated ×4, half replicated ×2, word as-is.
- Load extract:
  - Shift mem_rdata_i right by 8·addr[1:0].
  - Then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW passes through.
- Address, we, wdata, be and funct3 are registered on leaving IDLE and held constant through REQ.
- FSM states:
  - IDLE: stall_o = (MemRead_i|MemWrite_i) & aligned. On that condition go to REQ; otherwise stay.
  - REQ: mem_req_o=1, stall_o=1.
    - mem_ack_i=1: capture extracted load data into rdata_o, go to DONE.
    - Otherwise increment the wait counter. If TIMEOUT≠0 and the counter reaches TIMEOUT: drop the request, set err_o, set rdata_o=0, go to DONE.
  - DONE: stall_o=0, rdata_valid_o=1 for loads only. Inputs are ignored (the same instruction is still presented), and the FSM returns to IDLE unconditionally.
- The wait counter is 8 bits and is cleared on entry to REQ.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, err_o 0.
- Reset is asynchronous. Asserting start_i mid-access drops mem_req_o immediately and clears all state.
- Zero-wait memory (ack in the first REQ cycle):
  - cycle N: IDLE, stall high
  - cycle N+1: REQ
  - cycle N+2: DONE
  - The pipeline advances at the end of N+2.
- Each wait cycle adds 1. Total occupancy is 3+W cycles.
- Back-to-back memory ops: the next op is detected in the IDLE cycle after DONE. There is no lost cycle beyond DONE→IDLE.
- mem_ack_i high while mem_req_o=0 is ignored. Ack arriving in the same cycle the timeout count is reached wins, and err_o stays 0.
- Non-memory instructions pass with stall_o=0 and generate zero memory traffic.

## Test plan
- Aligned LW at 0x100, SRAM returns 0xDEADBEEF with ack in the first REQ cycle:
  - mem_be_o=1111, stall_o high for 2 cycles.
  - rdata_o=0xDEADBEEF with rdata_valid_o pulse in cycle N+2.
- LB at 0x103, then LBU at 0x103, word 0x80FF7F01:
  - LB: rdata_o=0xFFFFFF80, mem_be_o=1000.
  - LBU: rdata_o=0x00000080.
- SH at 0x202 with RDData_i=0x1234ABCD and ack after 3 wait cycles:
  - mem_we_o=1, mem_addr_o=0x200, mem_be_o=1100, mem_wdata_o=0xABCDABCD.
  - stall_o high 5 cycles; no rdata_valid_o.
- LW at 0x101:
  - No mem_req_o, stall_o stays 0.
  - misalign_o pulses 1 cycle later.
- TIMEOUT=4, ack never asserted:
  - mem_req_o high exactly 4 cycles, then err_o=1 (sticky), rdata_o=0, stall released.
- start_i pulsed low in the second REQ cycle:
  - mem_req_o, stall_o and err_o drop asynchronously; FSM resumes in IDLE.
  - A later ack is ignored.
